// File: rtl/datapath_seq.sv
// Single-bus register-file datapath: memory loads and two-operand ALU ops
// sequenced by a small FSM, one bus source per cycle.
module datapath_seq #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    localparam int AW = $clog2(NREGS),
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             in_clr,
    input  logic             in_start,
    input  logic             in_load,
    input  logic [3:0]       in_opcode,
    input  logic [AW-1:0]    in_ra,
    input  logic [AW-1:0]    in_rb,
    input  logic [AW-1:0]    in_rc,
    input  logic [WIDTH-1:0] in_mem_data,
    input  logic             in_mem_valid,
    output logic             out_busy,
    output logic             out_done,
    output logic             out_err,
    output logic [WIDTH-1:0] out_bus,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo
);

    typedef enum logic [2:0] {
        IDLE, LD_WAIT, LD_WB, OP_A, OP_B, OP_LO, OP_HI, DONE
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_SHL = 4'd4, OP_SHR = 4'd5, OP_MUL = 4'd6, OP_NOT = 4'd7;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     regs [NREGS];
    logic [WIDTH-1:0]     y, mdr, hi, lo, bus;
    logic [2*WIDTH-1:0]   z, alu_z;
    logic                 load_q;
    logic [3:0]           op_q;
    logic [AW-1:0]        ra_q, rb_q, rc_q;
    logic                 illegal;

    assign illegal = op_q[3];

    // Z upper half is zero except for MUL; illegal opcodes produce zero.
    always_comb begin
        alu_z = '0;
        case (op_q)
            OP_ADD:  alu_z[WIDTH-1:0] = y + bus;
            OP_SUB:  alu_z[WIDTH-1:0] = y - bus;
            OP_AND:  alu_z[WIDTH-1:0] = y & bus;
            OP_OR:   alu_z[WIDTH-1:0] = y | bus;
            OP_SHL:  alu_z[WIDTH-1:0] = y << bus[SW-1:0];
            OP_SHR:  alu_z[WIDTH-1:0] = y >> bus[SW-1:0];
            OP_MUL:  alu_z = {{WIDTH{1'b0}}, y} * {{WIDTH{1'b0}}, bus};
            OP_NOT:  alu_z[WIDTH-1:0] = ~bus;
            default: alu_z = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        bus       = '0;
        case (state)
            IDLE:    if (in_start) state_nxt = in_load ? LD_WAIT : OP_A;
            LD_WAIT: if (in_mem_valid) state_nxt = LD_WB;
            LD_WB: begin
                bus       = mdr;
                state_nxt = DONE;
            end
            OP_A: begin
                bus       = regs[ra_q];
                state_nxt = OP_B;
            end
            OP_B: begin
                bus       = regs[rb_q];
                state_nxt = OP_LO;
            end
            OP_LO: begin
                bus       = z[WIDTH-1:0];
                state_nxt = (op_q == OP_MUL) ? OP_HI : DONE;
            end
            OP_HI: begin
                bus       = z[2*WIDTH-1:WIDTH];
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_clr) begin
            state  <= IDLE;
            y      <= '0;
            z      <= '0;
            mdr    <= '0;
            hi     <= '0;
            lo     <= '0;
            load_q <= 1'b0;
            op_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            rc_q   <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_start) begin
                    load_q <= in_load;
                    op_q   <= in_opcode;
                    ra_q   <= in_ra;
                    rb_q   <= in_rb;
                    rc_q   <= in_rc;
                end
                LD_WAIT: if (in_mem_valid) mdr <= in_mem_data;
                LD_WB:   regs[rc_q] <= bus;
                OP_A:    y <= bus;
                OP_B:    z <= alu_z;
                OP_LO: if (!illegal) begin
                    regs[rc_q] <= bus;
                    lo         <= bus;
                end
                OP_HI:   hi <= bus;
                default: ;
            endcase
        end
    end

    assign out_busy = (state != IDLE);
    assign out_done = (state == DONE);
    assign out_err  = (state == DONE) && !load_q && illegal;
    assign out_bus  = bus;
    assign out_hi   = hi;
    assign out_lo   = lo;

endmodule

// File: tb/tb_datapath_seq.sv
// Randomized bench for datapath_seq: per-cycle bus/busy/done/err checks
// against an arithmetic reference model of the register file, HI and LO.
module tb_datapath_seq;

    localparam int W = 32;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          in_clr, in_start, in_load, in_mem_valid;
    logic [3:0]    in_opcode, in_ra, in_rb, in_rc;
    logic [W-1:0]  in_mem_data;
    logic          out_busy, out_done, out_err;
    logic [W-1:0]  out_bus, out_hi, out_lo;

    datapath_seq #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .in_clr(in_clr), .in_start(in_start), .in_load(in_load),
        .in_opcode(in_opcode), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
        .in_mem_data(in_mem_data), .in_mem_valid(in_mem_valid),
        .out_busy(out_busy), .out_done(out_done), .out_err(out_err),
        .out_bus(out_bus), .out_hi(out_hi), .out_lo(out_lo)
    );

    always #5 clk = ~clk;

    logic [W-1:0] m_r [N];
    logic [W-1:0] m_hi, m_lo;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a << b[4:0];
            4'd5: r = a >> b[4:0];
            4'd6: return 64'(a) * 64'(b);
            4'd7: r = ~b;
            default: return 64'd0;
        endcase
        return {32'd0, r};
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_r[i] = '0;
        m_hi = '0;
        m_lo = '0;
    endfunction

    // Drives one operation and checks every cycle from start to DONE.
    task automatic run_op(input bit ld, input logic [3:0] op, input logic [3:0] ra,
                          input logic [3:0] rb, input logic [3:0] rc,
                          input logic [W-1:0] data, input int wt);
        logic [W-1:0] exp_bus [$];
        logic [63:0]  z;
        bit           ill;
        int           last;
        ill = op[3];
        z   = ref_alu(op, m_r[ra], m_r[rb]);
        if (ld) begin
            repeat (wt + 1) exp_bus.push_back('0);
            exp_bus.push_back(data);
            exp_bus.push_back('0);
        end else begin
            exp_bus.push_back(m_r[ra]);
            exp_bus.push_back(m_r[rb]);
            exp_bus.push_back(z[31:0]);
            if (op == 4'd6) exp_bus.push_back(z[63:32]);
            exp_bus.push_back('0);
        end
        last = exp_bus.size() - 1;
        chk("idle_busy", out_busy, 0);
        chk("idle_bus", out_bus, 0);
        in_start = 1'b1; in_load = ld; in_opcode = op;
        in_ra = ra; in_rb = rb; in_rc = rc;
        in_mem_valid = 1'b0; in_mem_data = $urandom;
        step();
        for (int i = 0; i <= last; i++) begin
            // garbage on the request fields while busy must be ignored
            in_start = (i == last) ? 1'b0 : 1'($urandom);
            in_load = 1'($urandom); in_opcode = 4'($urandom);
            in_ra = 4'($urandom); in_rb = 4'($urandom); in_rc = 4'($urandom);
            if (ld && i <= wt) begin
                in_mem_valid = (i == wt);
                in_mem_data  = (i == wt) ? data : $urandom;
            end else begin
                in_mem_valid = 1'($urandom);
                in_mem_data  = $urandom;
            end
            chk("busy", out_busy, 1);
            chk("bus", out_bus, exp_bus[i]);
            chk("done", out_done, (i == last));
            if (i == last) chk("err", out_err, (!ld && ill));
            step();
        end
        in_start = 1'b0;
        if (ld) m_r[rc] = data;
        else if (!ill) begin
            m_r[rc] = z[31:0];
            m_lo    = z[31:0];
            if (op == 4'd6) m_hi = z[63:32];
        end
        chk("hi", out_hi, m_hi);
        chk("lo", out_lo, m_lo);
    endtask

    initial begin
        logic [3:0] op;
        in_clr = 1'b1; in_start = 1'b0; in_load = 1'b0; in_opcode = '0;
        in_ra = '0; in_rb = '0; in_rc = '0; in_mem_data = '0; in_mem_valid = 1'b0;
        model_clear();
        step(); step();
        in_clr = 1'b0;
        chk("rst_busy", out_busy, 0);
        chk("rst_done", out_done, 0);
        chk("rst_err", out_err, 0);
        chk("rst_bus", out_bus, 0);
        chk("rst_hi", out_hi, 0);
        chk("rst_lo", out_lo, 0);

        // AND after two immediate loads
        run_op(1, 0, 0, 0, 2, 32'h22, 0);
        run_op(1, 0, 0, 0, 4, 32'h24, 0);
        run_op(0, 4'd2, 2, 4, 5, 0, 0);
        chk("and_lo", out_lo, 32'h20);

        // full-width MUL
        run_op(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        run_op(1, 0, 0, 0, 2, 32'h2, 0);
        run_op(0, 4'd6, 1, 2, 3, 0, 0);
        chk("mul_lo", out_lo, 32'hFFFF_FFFE);
        chk("mul_hi", out_hi, 32'h1);

        // SUB wraps, HI untouched
        run_op(1, 0, 0, 0, 1, 32'h0, 0);
        run_op(1, 0, 0, 0, 2, 32'h1, 0);
        run_op(0, 4'd1, 1, 2, 6, 0, 0);
        chk("sub_lo", out_lo, 32'hFFFF_FFFF);
        chk("sub_hi", out_hi, 32'h1);

        // load with three stall cycles, then read it back via OR
        run_op(1, 0, 0, 0, 8, 32'hA5A5_A5A5, 3);
        run_op(0, 4'd3, 8, 8, 9, 0, 0);
        chk("ld_wait_lo", out_lo, 32'hA5A5_A5A5);

        // illegal opcode: err flagged, rc and LO untouched
        run_op(0, 4'b1010, 1, 2, 5, 0, 0);
        chk("ill_lo", out_lo, 32'hA5A5_A5A5);
        run_op(0, 4'd3, 5, 5, 10, 0, 0);
        chk("ill_r5", out_lo, 32'h20);

        // clear during OP_B of an ADD
        in_start = 1'b1; in_load = 1'b0; in_opcode = 4'd0;
        in_ra = 4'd1; in_rb = 4'd2; in_rc = 4'd11;
        step();
        in_start = 1'b0;
        step();
        chk("clr_in_opb_bus", out_bus, 32'h1);
        in_clr = 1'b1;
        step();
        in_clr = 1'b0;
        model_clear();
        chk("clr_busy", out_busy, 0);
        chk("clr_bus", out_bus, 0);
        chk("clr_done", out_done, 0);
        chk("clr_hi", out_hi, 0);
        chk("clr_lo", out_lo, 0);
        step();
        chk("clr_no_done", out_done, 0);
        run_op(0, 4'd3, 8, 2, 11, 0, 0);
        chk("clr_regs", out_lo, 0);

        for (int k = 0; k < 300; k++) begin
            op = 4'($urandom_range(0, 9));
            if (op > 4'd7) op = 4'($urandom_range(8, 15));
            if ($urandom_range(0, 9) < 3)
                run_op(1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                       $urandom, int'($urandom_range(0, 3)));
            else
                run_op(0, op, 4'($urandom), 4'($urandom), 4'($urandom), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
